// File: rtl/stream_fifo.sv
// ---------------------------------------------------------------------------
// stream_fifo
//
// First-word-fall-through valid/ready FIFO that buffers full-width words in
// front of the stream downsizer, so a wide producer can keep bursting while
// the narrow output path is still serialising an earlier word.
//
// Parameters
//   DW : data width in bits (DW_OUT*SCALE of the downstream downsizer)
//   AW : address width, depth = 2**AW words, AW >= 1
//
// Ports
//   clk        in   1     clock, rising edge
//   rst_n      in   1     asynchronous active-low reset
//   s_data_i   in   DW    write data
//   s_valid_i  in   1     write data valid
//   s_ready_o  out  1     FIFO can accept a word
//   m_data_o   out  DW    head-of-FIFO data (don't-care while m_valid_o=0)
//   m_valid_o  out  1     head word valid
//   m_ready_i  in   1     consumer accepts the head word
//   cnt_o      out  AW+1  number of stored words, 0..2**AW
// ---------------------------------------------------------------------------
module stream_fifo #(
  parameter int DW = 32,
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [DW-1:0] s_data_i,
  input  logic          s_valid_i,
  output logic          s_ready_o,
  output logic [DW-1:0] m_data_o,
  output logic          m_valid_o,
  input  logic          m_ready_i,
  output logic [AW:0]   cnt_o
);

  localparam int DEPTH = 1 << AW;

  // Word storage; deliberately has no reset so it maps onto plain registers
  // or distributed RAM without a reset network.
  logic [DW-1:0] mem [DEPTH];

  // Pointers carry one extra lap bit above the address bits, which makes
  // empty/full unambiguous and wrap-around free of special cases.
  logic [AW:0] wr_ptr_reg;
  logic [AW:0] rd_ptr_reg;

  // Post-reset guard: keeps s_ready_o low for the first cycle after rst_n
  // rises so no word is accepted on the release edge itself.
  logic rst_r;

  logic empty;
  logic full;
  logic wr;
  logic rd;

  // Status derived purely from registered pointers, so neither ready nor
  // valid has a combinational path from the opposite handshake input.
  assign empty = (wr_ptr_reg == rd_ptr_reg);
  assign full  = (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]) &&
                 (wr_ptr_reg[AW] != rd_ptr_reg[AW]);

  assign s_ready_o = !full && !rst_r;
  assign m_valid_o = !empty;

  assign wr = s_valid_i && s_ready_o;
  assign rd = m_valid_o && m_ready_i;

  // Modulo 2**(AW+1) difference is exactly the fill level, including the
  // full case where the lap bits differ.
  assign cnt_o = wr_ptr_reg - rd_ptr_reg;

  // Fall-through read straight from the array.
  assign m_data_o = mem[rd_ptr_reg[AW-1:0]];

  // Pointer and guard state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      rst_r      <= 1'b1;
    end else begin
      rst_r <= 1'b0;
      if (wr) begin
        wr_ptr_reg <= wr_ptr_reg + {{AW{1'b0}}, 1'b1};
      end
      if (rd) begin
        rd_ptr_reg <= rd_ptr_reg + {{AW{1'b0}}, 1'b1};
      end
    end
  end

  // Storage write. wr is forced low during reset through s_ready_o, so the
  // array needs no reset term of its own.
  always_ff @(posedge clk) begin
    if (wr) begin
      mem[wr_ptr_reg[AW-1:0]] <= s_data_i;
    end
  end

endmodule

// File: tb/tb_stream_fifo.sv
// ---------------------------------------------------------------------------
// tb_stream_fifo
//
// Directed bench for stream_fifo (DW=32, AW=4). Inputs change and outputs
// are sampled 1 time unit after each rising clock edge.
// ---------------------------------------------------------------------------
module tb_stream_fifo;

  localparam int DW = 32;
  localparam int AW = 4;

  logic          clk;
  logic          rst_n;
  logic [DW-1:0] s_data_i;
  logic          s_valid_i;
  logic          s_ready_o;
  logic [DW-1:0] m_data_o;
  logic          m_valid_o;
  logic          m_ready_i;
  logic [AW:0]   cnt_o;

  int checks;
  int errors;

  stream_fifo #(.DW(DW), .AW(AW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .s_data_i  (s_data_i),
    .s_valid_i (s_valid_i),
    .s_ready_o (s_ready_o),
    .m_data_o  (m_data_o),
    .m_valid_o (m_valid_o),
    .m_ready_i (m_ready_i),
    .cnt_o     (cnt_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // -------------------------------------------------------------------------
  task automatic test_reset();
    rst_n     = 1'b0;
    s_valid_i = 1'b1;
    s_data_i  = 32'hCAFE0000;
    m_ready_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (s_ready_o !== 1'b0) begin
        errors++; $display("FAIL reset_ready cyc%0d: got %b want 0", i, s_ready_o);
      end
      checks++;
      if (m_valid_o !== 1'b0) begin
        errors++; $display("FAIL reset_valid cyc%0d: got %b want 0", i, m_valid_o);
      end
      checks++;
      if (cnt_o !== 5'd0) begin
        errors++; $display("FAIL reset_cnt cyc%0d: got %0d want 0", i, cnt_o);
      end
    end
    rst_n = 1'b1;
    #1;
    checks++;
    if (s_ready_o !== 1'b0) begin
      errors++; $display("FAIL guard_ready: got %b want 0", s_ready_o);
    end
    checks++;
    if (m_valid_o !== 1'b0 || cnt_o !== 5'd0) begin
      errors++; $display("FAIL guard_state: valid %b cnt %0d want 0 0", m_valid_o, cnt_o);
    end
    tick();
    checks++;
    if (s_ready_o !== 1'b1) begin
      errors++; $display("FAIL post_guard_ready: got %b want 1", s_ready_o);
    end
    checks++;
    if (m_valid_o !== 1'b0 || cnt_o !== 5'd0) begin
      errors++; $display("FAIL post_guard_state: valid %b cnt %0d want 0 0", m_valid_o, cnt_o);
    end
    s_valid_i = 1'b0;
    $display("reset: guard released");
  endtask

  // -------------------------------------------------------------------------
  task automatic test_fill();
    m_ready_i = 1'b0;
    for (int i = 0; i < 16; i++) begin
      s_data_i  = 32'(i);
      s_valid_i = 1'b1;
      tick();
      checks++;
      if (cnt_o !== 5'(i + 1)) begin
        errors++; $display("FAIL fill_cnt w%0d: got %0d want %0d", i, cnt_o, i + 1);
      end
      $display("fill: wrote %08h", 32'(i));
    end
    checks++;
    if (s_ready_o !== 1'b0) begin
      errors++; $display("FAIL full_ready: got %b want 0", s_ready_o);
    end
    s_data_i = 32'hDEADBEEF;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (cnt_o !== 5'd16 || s_ready_o !== 1'b0) begin
        errors++; $display("FAIL full_hold cyc%0d: cnt %0d ready %b want 16 0", i, cnt_o, s_ready_o);
      end
    end
    s_valid_i = 1'b0;
    m_ready_i = 1'b1;
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (m_valid_o !== 1'b1 || m_data_o !== 32'(i)) begin
        errors++; $display("FAIL drain r%0d: valid %b data %08h want 1 %08h", i, m_valid_o, m_data_o, 32'(i));
      end
      $display("fill: read %08h", m_data_o);
      tick();
      if (i == 0) begin
        checks++;
        if (s_ready_o !== 1'b1) begin
          errors++; $display("FAIL ready_after_read: got %b want 1", s_ready_o);
        end
      end
    end
    m_ready_i = 1'b0;
    checks++;
    if (cnt_o !== 5'd0 || m_valid_o !== 1'b0) begin
      errors++; $display("FAIL drained: cnt %0d valid %b want 0 0", cnt_o, m_valid_o);
    end
  endtask

  // -------------------------------------------------------------------------
  task automatic test_latency();
    s_data_i  = 32'hA5A5A5A5;
    s_valid_i = 1'b1;
    checks++;
    if (m_valid_o !== 1'b0) begin
      errors++; $display("FAIL fwft_early: valid %b want 0", m_valid_o);
    end
    tick();
    s_valid_i = 1'b0;
    checks++;
    if (m_valid_o !== 1'b1 || m_data_o !== 32'hA5A5A5A5) begin
      errors++; $display("FAIL fwft: valid %b data %08h want 1 a5a5a5a5", m_valid_o, m_data_o);
    end
    $display("latency: read %08h", m_data_o);
    m_ready_i = 1'b1;
    tick();
    m_ready_i = 1'b0;
    checks++;
    if (cnt_o !== 5'd0 || m_valid_o !== 1'b0) begin
      errors++; $display("FAIL fwft_drain: cnt %0d valid %b want 0 0", cnt_o, m_valid_o);
    end
  endtask

  // -------------------------------------------------------------------------
  task automatic test_back_to_back();
    m_ready_i = 1'b0;
    for (int i = 0; i < 8; i++) begin
      s_data_i  = 32'h100 + 32'(i);
      s_valid_i = 1'b1;
      tick();
    end
    checks++;
    if (cnt_o !== 5'd8) begin
      errors++; $display("FAIL preload_cnt: got %0d want 8", cnt_o);
    end
    m_ready_i = 1'b1;
    for (int k = 0; k < 20; k++) begin
      s_data_i = 32'h108 + 32'(k);
      checks++;
      if (m_valid_o !== 1'b1 || m_data_o !== 32'h100 + 32'(k)) begin
        errors++; $display("FAIL b2b_data c%0d: valid %b data %08h want 1 %08h", k, m_valid_o, m_data_o, 32'h100 + 32'(k));
      end
      $display("b2b: wrote %08h read %08h", s_data_i, m_data_o);
      tick();
      checks++;
      if (cnt_o !== 5'd8) begin
        errors++; $display("FAIL b2b_cnt c%0d: got %0d want 8", k, cnt_o);
      end
    end
    s_valid_i = 1'b0;
    for (int j = 0; j < 8; j++) begin
      checks++;
      if (m_data_o !== 32'h114 + 32'(j)) begin
        errors++; $display("FAIL b2b_tail r%0d: got %08h want %08h", j, m_data_o, 32'h114 + 32'(j));
      end
      tick();
    end
    m_ready_i = 1'b0;
    checks++;
    if (cnt_o !== 5'd0) begin
      errors++; $display("FAIL b2b_empty: got %0d want 0", cnt_o);
    end
  endtask

  // -------------------------------------------------------------------------
  task automatic test_wrap();
    int wn;
    int rn;
    int mc;
    int cyc;
    logic exp_ready;
    logic exp_valid;
    logic do_wr;
    logic do_rd;
    wn = 0; rn = 0; mc = 0; cyc = 0;
    while (rn < 100 && cyc < 3000) begin
      s_valid_i = (wn < 100) && ($urandom_range(1, 0) == 1);
      s_data_i  = 32'h200 + 32'(wn);
      m_ready_i = ($urandom_range(1, 0) == 1);
      exp_ready = (mc < 16);
      exp_valid = (mc > 0);
      checks++;
      if (s_ready_o !== exp_ready || m_valid_o !== exp_valid) begin
        errors++; $display("FAIL wrap_flags c%0d: ready %b valid %b want %b %b", cyc, s_ready_o, m_valid_o, exp_ready, exp_valid);
      end
      do_wr = s_valid_i && exp_ready;
      do_rd = m_ready_i && exp_valid;
      if (do_rd) begin
        checks++;
        if (m_data_o !== 32'h200 + 32'(rn)) begin
          errors++; $display("FAIL wrap_data r%0d: got %08h want %08h", rn, m_data_o, 32'h200 + 32'(rn));
        end
        $display("wrap: read %08h", m_data_o);
      end
      tick();
      if (do_wr) wn++;
      if (do_rd) rn++;
      mc  = wn - rn;
      cyc++;
      checks++;
      if (cnt_o !== 5'(mc)) begin
        errors++; $display("FAIL wrap_cnt c%0d: got %0d want %0d", cyc, cnt_o, mc);
      end
    end
    s_valid_i = 1'b0;
    m_ready_i = 1'b0;
    checks++;
    if (rn != 100) begin
      errors++; $display("FAIL wrap_timeout: received %0d want 100", rn);
    end
  endtask

  // -------------------------------------------------------------------------
  task automatic test_reset_mid();
    m_ready_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      s_data_i  = 32'h300 + 32'(i);
      s_valid_i = 1'b1;
      tick();
    end
    s_valid_i = 1'b0;
    checks++;
    if (cnt_o !== 5'd5 || m_valid_o !== 1'b1) begin
      errors++; $display("FAIL mid_preload: cnt %0d valid %b want 5 1", cnt_o, m_valid_o);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (m_valid_o !== 1'b0 || cnt_o !== 5'd0) begin
      errors++; $display("FAIL mid_async: valid %b cnt %0d want 0 0", m_valid_o, cnt_o);
    end
    #4;
    rst_n = 1'b1;
    #1;
    checks++;
    if (s_ready_o !== 1'b0) begin
      errors++; $display("FAIL mid_guard: ready %b want 0", s_ready_o);
    end
    tick();
    checks++;
    if (s_ready_o !== 1'b1 || m_valid_o !== 1'b0) begin
      errors++; $display("FAIL mid_release: ready %b valid %b want 1 0", s_ready_o, m_valid_o);
    end
    s_data_i  = 32'h12345678;
    s_valid_i = 1'b1;
    tick();
    s_valid_i = 1'b0;
    checks++;
    if (m_valid_o !== 1'b1 || m_data_o !== 32'h12345678 || cnt_o !== 5'd1) begin
      errors++; $display("FAIL mid_first: valid %b data %08h cnt %0d want 1 12345678 1", m_valid_o, m_data_o, cnt_o);
    end
    $display("reset_mid: read %08h", m_data_o);
    m_ready_i = 1'b1;
    tick();
    m_ready_i = 1'b0;
    checks++;
    if (cnt_o !== 5'd0 || m_valid_o !== 1'b0) begin
      errors++; $display("FAIL mid_drain: cnt %0d valid %b want 0 0", cnt_o, m_valid_o);
    end
  endtask

  // -------------------------------------------------------------------------
  initial begin
    checks    = 0;
    errors    = 0;
    rst_n     = 1'b0;
    s_valid_i = 1'b0;
    s_data_i  = '0;
    m_ready_i = 1'b0;
    test_reset();
    test_fill();
    test_latency();
    test_back_to_back();
    test_wrap();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/stream_fifo.md
# stream_fifo

Synchronous valid/ready FIFO that buffers full-width words ahead of the stream downsizer. It decouples the wide producer (DMA/bus side) from the narrow serialised output path, so that producer bursts can continue while the downsizer is still emitting the slices of an earlier word. The FIFO has first-word-fall-through behaviour and reports its fill level for flow-control and debug use.

## Interface
- DW, 32: data width in bits. Set to DW_OUT*SCALE of the downstream downsizer.
- AW, 4: address width. Depth = 2^AW words; AW ≥ 1.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- s_data_i  in  DW  write data.
- s_valid_i  in  1  write data valid.
- s_ready_o  out  1  FIFO can accept a word.
- m_data_o  out  DW  head-of-FIFO data.
- m_valid_o  out  1  head word valid.
- m_ready_i  in  1  consumer accepts the head word.
- cnt_o  out  AW+1  number of stored words, 0..2^AW.

## Operation
- Reset is asynchronous and active-low. While rst_n=0:
  - write and read pointers = 0;
  - m_valid_o = 0, cnt_o = 0, s_ready_o = 0;
  - storage contents are not reset.
- Post-reset guard: a 1-bit register rst_r is set by reset and cleared on the first clk edge after rst_n rises. s_ready_o is held low while rst_r=1. Ready therefore first asserts one cycle after reset is released.
- Write handshake: wr = s_valid_i & s_ready_o. On wr, s_data_i is stored at mem[wr_ptr] and wr_ptr increments.
- Read handshake: rd = m_valid_o & m_ready_i. On rd, rd_ptr increments.
- Pointers are AW+1 bits. The low AW bits address storage. The MSB is the lap bit, so wrap-around needs no special case.
  - empty: wr_ptr == rd_ptr.
  - full: low bits equal and MSBs differ.
- s_ready_o = !full & !rst_r.
- m_valid_o = !empty.
- m_data_o = mem[rd_ptr[AW-1:0]], read combinationally from the register array. m_data_o is don't-care when m_valid_o=0.
- cnt_o = wr_ptr - rd_ptr, computed modulo 2^(AW+1).
- Simultaneous wr and rd:
  - when neither empty nor full, both pointers advance and cnt_o is unchanged;
  - when full, s_ready_o=0, so only the read occurs;
  - when empty, m_valid_o=0, so only the write occurs. There is no combinational pass-through from s_* to m_*.
- No combinational path exists from s_valid_i to s_ready_o, or from m_ready_i to m_valid_o. The ready/valid outputs depend only on registered state.
- Data ordering is strict FIFO. No word is lost or duplicated under any valid/ready pattern.

## Timing
- Write latency: a word accepted at edge N appears on m_data_o with m_valid_o=1 after edge N (in cycle N+1) if the FIFO was empty. Latency is 1 cycle.
- Throughput: one write and one read per cycle, sustained.
- s_ready_o deasserts in the cycle after the write that fills the FIFO, and reasserts in the cycle after the first read from full.
- cnt_o updates on the same edge as the pointers.
- Reset mid-operation asynchronously clears all state. Words in flight are discarded. m_valid_o drops immediately, without waiting for clk.
- m_data_o and m_valid_o stay stable while m_valid_o=1 and m_ready_i=0.

## Test plan
- Reset/guard: hold rst_n=0 for 3 cycles with s_valid_i=1, then release. Required: s_ready_o=0 during reset and for the first cycle after release, then 1. m_valid_o=0 and cnt_o=0 throughout the guard.
- Fill/full (DW=32, AW=4): with m_ready_i=0, write 0x00000000..0x0000000F. Required:
  - cnt_o reaches 16 and s_ready_o=0;
  - a 17th word 0xDEADBEEF held valid is not accepted;
  - after draining, the output order is 0x0..0xF;
  - cnt_o returns to 0 and m_valid_o=0.
- Latency/FWFT: write 0xA5A5A5A5 into an empty FIFO at edge N. Required: m_valid_o=1 and m_data_o=0xA5A5A5A5 in cycle N+1, not earlier.
- Concurrent read/write: preload 8 words, then drive s_valid_i=m_ready_i=1 for 20 cycles. Required: cnt_o stays at 8 every cycle, and the output sequence continues in write order.
- Wrap-around with backpressure: 100 incrementing words, random s_valid_i and m_ready_i at roughly 50% each. Required: all 100 words are received in order, and cnt_o always equals writes minus reads (verified across multiple pointer laps).
- Reset mid-stream: with cnt_o=5, pulse rst_n low for half a cycle. Required: m_valid_o and cnt_o fall to 0 without a clock edge. After the guard cycle, a new write of 0x12345678 is the first word read out.
